mmio_io_ctrl: RTL and testbench

- Parametrised memory-mapped I/O controller between the processor data port and board pins.
- Has N input channels, each with a 2-flop synchroniser and a debouncer, plus sticky change-status bits.
- Has M writable output channels with read-back.
- Wrapper ORs its `hit` into the dmem read mux: `q_dmem = hit ? rdata : RAM`.

---
 rtl/mmio_io_pkg.sv | 31 +++
 rtl/mmio_debounce.sv | 51 +++++
 rtl/mmio_io_ctrl.sv | 147 ++++++++++++++
 tb/tb_mmio_io_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_io_pkg.sv
// Shared constants and register-map helpers for the memory-mapped I/O controller.
// Offsets are relative to BASE_ADDR; the MASK offset is only decoded under MMIO_IO_IRQ_EN.
package mmio_io_pkg;

  // A 1 written to a STATUS bit clears it.
  localparam bit STATUS_W1C = 1'b1;

  function automatic int unsigned in_off(input int unsigned i);
    return i;
  endfunction

  function automatic int unsigned out_off(input int unsigned num_in, input int unsigned j);
    return num_in + j;
  endfunction

  function automatic int unsigned status_off(input int unsigned num_in,
                                             input int unsigned num_out);
    return num_in + num_out;
  endfunction

  function automatic int unsigned mask_off(input int unsigned num_in,
                                           input int unsigned num_out);
    return num_in + num_out + 1;
  endfunction

  // One spare bit so DEBOUNCE_CYCLES-1 always fits, including DEBOUNCE_CYCLES==1.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return int'($clog2(cycles)) + 1;
  endfunction

endpackage

// File: rtl/mmio_debounce.sv
// One input channel: 2-flop synchroniser followed by a stable-count debouncer.
// changed pulses for the single cycle whose posedge loads a new debounced value.
module mmio_debounce
  import mmio_io_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] deb,
  output logic             changed
);

  localparam int unsigned   CntW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_deb;
  logic [CntW-1:0]  r_cnt;
  logic             w_accept;

  assign w_accept = (r_s2 != r_deb) && (r_cnt == CntLast);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_deb <= '0;
      r_cnt <= '0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
      // Any return to the accepted value restarts the stability count.
      if (r_s2 == r_deb) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign deb     = r_deb;
  assign changed = w_accept;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped switch/LED controller: debounced inputs, writable outputs, sticky W1C status.
// Optional MASK register and registered irq output when MMIO_IO_IRQ_EN is defined.
module mmio_io_ctrl
  import mmio_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'd4000,
  parameter int unsigned NUM_IN_CH       = 1,
  parameter int unsigned NUM_OUT_CH      = 1,
  parameter int unsigned IN_WIDTH        = 16,
  parameter int unsigned OUT_WIDTH       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [31:0]                      addr,
  input  logic                             wren,
  input  logic [31:0]                      wdata,
  input  logic [NUM_IN_CH*IN_WIDTH-1:0]    sw_in,
  output logic [NUM_OUT_CH*OUT_WIDTH-1:0]  led_out,
`ifdef MMIO_IO_IRQ_EN
  output logic                             irq,
`endif
  output logic                             hit,
  output logic [31:0]                      rdata
);

  localparam int unsigned StatusOff = status_off(NUM_IN_CH, NUM_OUT_CH);
`ifdef MMIO_IO_IRQ_EN
  localparam int unsigned MaskOff   = mask_off(NUM_IN_CH, NUM_OUT_CH);
  localparam int unsigned LastOff   = MaskOff;
`else
  localparam int unsigned LastOff   = StatusOff;
`endif

  logic [31:0]           w_off;
  logic                  w_below;
  logic                  w_wr;
  logic [IN_WIDTH-1:0]   w_deb [NUM_IN_CH];
  logic [NUM_IN_CH-1:0]  w_changed;
  logic [NUM_IN_CH-1:0]  w_clr;
  logic [NUM_IN_CH-1:0]  w_status_d;
  logic [OUT_WIDTH-1:0]  r_out [NUM_OUT_CH];
  logic [NUM_IN_CH-1:0]  r_status;
  logic                  w_unused_wdata;

  assign w_unused_wdata = ^wdata;

  // Offset is only meaningful when addr >= BASE_ADDR, so the subtraction never wraps into a hit.
  assign w_below = (addr < BASE_ADDR);
  assign w_off   = addr - BASE_ADDR;
  assign hit     = !w_below && (w_off <= 32'(LastOff));
  assign w_wr    = wren && hit;

  for (genvar gi = 0; gi < NUM_IN_CH; gi++) begin : g_in
    mmio_debounce #(
      .WIDTH          (IN_WIDTH),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock  (clock),
      .reset  (reset),
      .raw    (sw_in[gi*IN_WIDTH +: IN_WIDTH]),
      .deb    (w_deb[gi]),
      .changed(w_changed[gi])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int j = 0; j < NUM_OUT_CH; j++) begin
        r_out[j] <= '0;
      end
    end else if (w_wr) begin
      for (int j = 0; j < NUM_OUT_CH; j++) begin
        if (w_off == 32'(out_off(NUM_IN_CH, j))) begin
          r_out[j] <= wdata[OUT_WIDTH-1:0];
        end
      end
    end
  end

  for (genvar gj = 0; gj < NUM_OUT_CH; gj++) begin : g_out
    assign led_out[gj*OUT_WIDTH +: OUT_WIDTH] = r_out[gj];
  end

  assign w_clr = wdata[NUM_IN_CH-1:0] & {NUM_IN_CH{STATUS_W1C}};

  // Clear first, then OR in new changes so a same-cycle set survives the W1C.
  always_comb begin
    w_status_d = r_status;
    if (w_wr && (w_off == 32'(StatusOff))) begin
      w_status_d = r_status & ~w_clr;
    end
    w_status_d = w_status_d | w_changed;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_status <= '0;
    end else begin
      r_status <= w_status_d;
    end
  end

`ifdef MMIO_IO_IRQ_EN
  logic [NUM_IN_CH-1:0] r_mask;
  logic                 r_irq;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr && (w_off == 32'(MaskOff))) begin
        r_mask <= wdata[NUM_IN_CH-1:0];
      end
      r_irq <= |(r_status & r_mask);
    end
  end

  assign irq = r_irq;
`endif

  always_comb begin
    rdata = '0;
    if (hit) begin
      for (int i = 0; i < NUM_IN_CH; i++) begin
        if (w_off == 32'(in_off(i))) begin
          rdata = 32'(w_deb[i]);
        end
      end
      for (int j = 0; j < NUM_OUT_CH; j++) begin
        if (w_off == 32'(out_off(NUM_IN_CH, j))) begin
          rdata = 32'(r_out[j]);
        end
      end
      if (w_off == 32'(StatusOff)) begin
        rdata = 32'(r_status);
      end
`ifdef MMIO_IO_IRQ_EN
      if (w_off == 32'(MaskOff)) begin
        rdata = 32'(r_mask);
      end
`endif
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model (default build, MMIO_IO_IRQ_EN undefined).
module tb_mmio_io_ctrl;

  localparam int D = 4;

  logic        clock;
  logic        reset;
  logic [31:0] addr;
  logic        wren;
  logic [31:0] wdata;
  logic [31:0] sw_in;
  logic [31:0] led_out;
  logic        hit;
  logic [31:0] rdata;
`ifdef MMIO_IO_IRQ_EN
  logic        irq;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state.
  logic [31:0] m_s1, m_s2;
  logic [15:0] m_deb [2];
  int          m_run [2];
  logic [15:0] m_out [2];
  logic [1:0]  m_status;

  mmio_io_ctrl #(
    .BASE_ADDR      (32'd4000),
    .NUM_IN_CH      (2),
    .NUM_OUT_CH     (2),
    .IN_WIDTH       (16),
    .OUT_WIDTH      (16),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .addr   (addr),
    .wren   (wren),
    .wdata  (wdata),
    .sw_in  (sw_in),
    .led_out(led_out),
`ifdef MMIO_IO_IRQ_EN
    .irq    (irq),
`endif
    .hit    (hit),
    .rdata  (rdata)
  );

  always #5 clock = ~clock;

  function automatic logic exp_hit(input logic [31:0] a);
    return (a >= 32'd4000) && (a <= 32'd4004);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (!exp_hit(a)) return 32'd0;
    case (a - 32'd4000)
      32'd0:   return {16'd0, m_deb[0]};
      32'd1:   return {16'd0, m_deb[1]};
      32'd2:   return {16'd0, m_out[0]};
      32'd3:   return {16'd0, m_out[1]};
      default: return {30'd0, m_status};
    endcase
  endfunction

  // An input is accepted once the synchronised pin has disagreed with the
  // accepted value for D consecutive samples; the sync path delays pins by 2.
  task automatic model_edge();
    logic [1:0]  set;
    logic [1:0]  clr;
    logic [15:0] cur;
    if (reset === 1'b0) begin
      m_s1 = '0; m_s2 = '0; m_status = '0;
      for (int c = 0; c < 2; c++) begin
        m_deb[c] = '0; m_run[c] = 0; m_out[c] = '0;
      end
    end else begin
      set = '0;
      clr = '0;
      for (int c = 0; c < 2; c++) begin
        cur = m_s2[c*16 +: 16];
        if (cur != m_deb[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == D) begin
            m_deb[c] = cur;
            m_run[c] = 0;
            set[c]   = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = sw_in;
      if (wren && exp_hit(addr)) begin
        case (addr - 32'd4000)
          32'd2:   m_out[0] = wdata[15:0];
          32'd3:   m_out[1] = wdata[15:0];
          32'd4:   clr = wdata[1:0];
          default: ;
        endcase
      end
      m_status = (m_status & ~clr) | set;
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic do_reset(input logic [31:0] pins);
    reset = 1'b0; sw_in = pins; wren = 1'b0; addr = 32'd4000; wdata = '0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; sw_in = 32'hFFFF_FFFF; wren = 1'b1; addr = 32'd4002; wdata = 32'hFFFF_FFFF;
    cycle();
    cycle();
    wren = 1'b0; addr = 32'd4004; #1;
    n_cmp++;
    if (led_out !== 32'd0) begin
      n_fail++; $display("FAIL reset_led: got %h expected %h", led_out, 32'd0);
    end
    n_cmp++;
    if (hit !== 1'b1 || rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_status: got hit=%b %h expected hit=1 %h", hit, rdata, 0);
    end
    reset = 1'b1; addr = 32'd4000;
    for (int k = 1; k <= 7; k++) begin
      logic [31:0] e;
      cycle(); #1;
      e = (k >= 6) ? 32'h0000_FFFF : 32'd0;
      n_cmp++;
      if (rdata !== e) begin
        n_fail++; $display("FAIL reset_in0_k%0d: got %h expected %h", k, rdata, e);
      end
    end
    addr = 32'd4004; #1;
    n_cmp++;
    if (rdata !== 32'd3) begin
      n_fail++; $display("FAIL reset_status_after: got %h expected %h", rdata, 32'd3);
    end
  endtask

  task automatic test_debounce();
    do_reset(32'd0);
    cycle();
    cycle();
    sw_in = 32'h0000_A5A5; addr = 32'd4000;
    for (int k = 1; k <= 7; k++) begin
      logic [31:0] e;
      cycle(); #1;
      e = (k >= 6) ? 32'h0000_A5A5 : 32'd0;
      n_cmp++;
      if (rdata !== e) begin
        n_fail++; $display("FAIL debounce_k%0d: got %h expected %h", k, rdata, e);
      end
    end
    addr = 32'd4004; #1;
    n_cmp++;
    if (rdata !== 32'd1) begin
      n_fail++; $display("FAIL debounce_status: got %h expected %h", rdata, 32'd1);
    end
  endtask

  task automatic test_bounce();
    do_reset(32'd0);
    cycle();
    cycle();
    addr = 32'd4001;
    for (int k = 1; k <= 12; k++) begin
      logic [31:0] e;
      sw_in = (k == 4) ? 32'd0 : 32'h00FF_0000;
      cycle(); #1;
      e = (k >= 10) ? 32'h0000_00FF : 32'd0;
      n_cmp++;
      if (rdata !== e) begin
        n_fail++; $display("FAIL bounce_k%0d: got %h expected %h", k, rdata, e);
      end
    end
  endtask

  task automatic test_output();
    do_reset(32'h0000_1234);
    for (int k = 0; k < 8; k++) cycle();
    addr = 32'd4003; wren = 1'b1; wdata = 32'hDEAD_BEEF;
    cycle();
    addr = 32'd4002; wdata = 32'hCAFE_0042;
    cycle();
    wren = 1'b0; addr = 32'd4003; #1;
    n_cmp++;
    if (led_out !== 32'hBEEF_0042) begin
      n_fail++; $display("FAIL out_led: got %h expected %h", led_out, 32'hBEEF_0042);
    end
    n_cmp++;
    if (rdata !== 32'h0000_BEEF) begin
      n_fail++; $display("FAIL out_read1: got %h expected %h", rdata, 32'h0000_BEEF);
    end
    addr = 32'd4000; wren = 1'b1; wdata = 32'd0;
    cycle();
    wren = 1'b0; #1;
    n_cmp++;
    if (rdata !== 32'h0000_1234) begin
      n_fail++; $display("FAIL out_in_ro: got %h expected %h", rdata, 32'h0000_1234);
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] wv [3] = '{32'd1, 32'd0, 32'd1};
    logic [31:0] ev [3] = '{32'd1, 32'd1, 32'd0};
    do_reset(32'd0);
    cycle();
    cycle();
    sw_in = 32'h0000_A5A5; addr = 32'd4004;
    for (int k = 1; k <= 5; k++) cycle();
    for (int s = 0; s < 3; s++) begin
      wren = 1'b1; wdata = wv[s];
      cycle();
      wren = 1'b0; #1;
      n_cmp++;
      if (rdata !== ev[s]) begin
        n_fail++; $display("FAIL w1c_step%0d: got %h expected %h", s, rdata, ev[s]);
      end
    end
  endtask

  task automatic test_decode();
    logic [31:0] al [4] = '{32'd3999, 32'd4005, 32'hFFFF_FFFF, 32'd0};
    for (int s = 0; s < 4; s++) begin
      addr = al[s]; wren = 1'b1; wdata = $urandom; #1;
      n_cmp++;
      if (hit !== 1'b0 || rdata !== 32'd0) begin
        n_fail++; $display("FAIL decode_%h: got hit=%b %h expected hit=0 0", al[s], hit, rdata);
      end
      cycle();
      wren = 1'b0; addr = 32'd4004; #1;
      n_cmp++;
      if (led_out !== {m_out[1], m_out[0]} || rdata !== exp_rdata(addr)) begin
        n_fail++; $display("FAIL decode_nowrite_%h: got %h/%h expected %h/%h", al[s], led_out,
                           rdata, {m_out[1], m_out[0]}, exp_rdata(addr));
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] vals [4] = '{16'h0000, 16'h5A5A, 16'hFFFF, 16'h0F0F};
    do_reset(32'd0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        int c;
        c = $urandom_range(0, 1);
        sw_in[c*16 +: 16] = vals[$urandom_range(0, 3)];
      end
      addr  = 32'd3998 + 32'($urandom_range(0, 8));
      wren  = ($urandom_range(0, 2) == 0);
      wdata = $urandom;
      reset = ($urandom_range(0, 149) != 0);
      #1;
      n_cmp++;
      if (hit !== exp_hit(addr) || rdata !== exp_rdata(addr) ||
          led_out !== {m_out[1], m_out[0]}) begin
        n_fail++;
        $display("FAIL random_%0d addr=%0d: got hit=%b rd=%h led=%h expected hit=%b rd=%h led=%h",
                 n, addr, hit, rdata, led_out, exp_hit(addr), exp_rdata(addr),
                 {m_out[1], m_out[0]});
      end
      cycle();
    end
    reset = 1'b1;
  endtask

  initial begin
    clock = 1'b0; reset = 1'b0; wren = 1'b0; addr = '0; wdata = '0; sw_in = '0;
    m_s1 = '0; m_s2 = '0; m_status = '0;
    for (int c = 0; c < 2; c++) begin
      m_deb[c] = '0; m_run[c] = 0; m_out[c] = '0;
    end
    @(negedge clock);
    test_reset();
    test_debounce();
    test_bounce();
    test_output();
    test_w1c_race();
    test_decode();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
